// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath stages.
package conv_pkg;

  localparam int CONV_WIDTH = 14;
  localparam int CONV_TAPS  = 9;
  localparam int CONV_SUM_W = CONV_WIDTH + 4;
  localparam int TAP_W      = 4;

  localparam logic [TAP_W-1:0] MUX_SEL_IDLE = 4'd9;
  localparam int               PIX_MAX      = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/conv_tap_counter.sv
// Tap index counter for 3x3 window traversal; raises `last` on the final tap.
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int TAPS  = CONV_TAPS,
  parameter int CNT_W = TAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] tap_cnt,
  output logic             last
);

  logic [CNT_W-1:0] tap_cnt_q;
  logic [CNT_W-1:0] tap_cnt_d;

  always_comb begin
    tap_cnt_d = tap_cnt_q;
    if (clr) begin
      tap_cnt_d = '0;
    end else if (en) begin
      tap_cnt_d = tap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt_q <= '0;
    end else begin
      tap_cnt_q <= tap_cnt_d;
    end
  end

  assign tap_cnt = tap_cnt_q;
  assign last    = (tap_cnt_q == CNT_W'(TAPS - 1));

endmodule

// File: rtl/conv_accumulator.sv
// Sequential 9-tap accumulate stage with valid/ready result port.
// Build option: define CONV_ACC_CLAMP_EN to clamp the result to the 8-bit pixel range.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int TAPS  = CONV_TAPS,
  parameter int SUM_W = WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  output logic [TAP_W-1:0]        mux_sel,
  input  logic signed [WIDTH-1:0] in_adder,
  input  logic                    in_adder_valid,
  output logic signed [SUM_W-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    tap_err
);

  acc_state_t              state_q, state_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] res_q, res_d;
  logic                    tap_err_q, tap_err_d;

  logic                    cnt_clr;
  logic                    cnt_en;
  logic [TAP_W-1:0]        tap_cnt;
  logic                    tap_last;
  logic signed [SUM_W-1:0] term_ext;
  logic signed [SUM_W-1:0] acc_sum;

  function automatic logic signed [SUM_W-1:0] fmt_result(input logic signed [SUM_W-1:0] v);
`ifdef CONV_ACC_CLAMP_EN
    if (v < 0) begin
      return '0;
    end else if (v > $signed(SUM_W'(PIX_MAX))) begin
      return $signed(SUM_W'(PIX_MAX));
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  conv_tap_counter #(
    .TAPS  (TAPS),
    .CNT_W (TAP_W)
  ) u_tap_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .tap_cnt (tap_cnt),
    .last    (tap_last)
  );

  assign term_ext = {{(SUM_W - WIDTH){in_adder[WIDTH-1]}}, in_adder};
  assign acc_sum  = acc_q + term_ext;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    res_d      = res_q;
    tap_err_d  = tap_err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    prod_ready = 1'b0;
    res_valid  = 1'b0;
    mux_sel    = MUX_SEL_IDLE;
    unique case (state_q)
      IDLE: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          acc_d   = '0;
          cnt_clr = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        mux_sel = tap_cnt;
        cnt_en  = !tap_last;
        // A missing product is dropped from the sum and flagged, never stalled on.
        if (in_adder_valid) begin
          acc_d = acc_sum;
        end else begin
          tap_err_d = 1'b1;
        end
        if (tap_last) begin
          res_d   = fmt_result(acc_d);
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          prod_ready = 1'b1;
          if (prod_valid) begin
            acc_d   = '0;
            cnt_clr = 1'b1;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      res_q     <= '0;
      tap_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      tap_err_q <= tap_err_d;
    end
  end

  assign res_data = res_q;
  assign tap_err  = tap_err_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Scoreboard bench for conv_accumulator: models the product mux and the expected sums.
module tb_conv_accumulator;

  localparam int WIDTH = 14;
  localparam int SUM_W = 18;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    prod_valid;
  logic                    prod_ready;
  logic [3:0]              mux_sel;
  logic signed [WIDTH-1:0] in_adder;
  logic                    in_adder_valid;
  logic signed [SUM_W-1:0] res_data;
  logic                    res_valid;
  logic                    res_ready;
  logic                    tap_err;

  logic signed [WIDTH-1:0] prods [0:8];
  int                      bad_tap = -1;
  logic signed [SUM_W-1:0] exp_q [$];
  int                      asserts = 0;
  int                      fails = 0;

  always #5 clk = ~clk;

  conv_accumulator dut (
    .clk            (clk),
    .rst            (rst),
    .prod_valid     (prod_valid),
    .prod_ready     (prod_ready),
    .mux_sel        (mux_sel),
    .in_adder       (in_adder),
    .in_adder_valid (in_adder_valid),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .tap_err        (tap_err)
  );

  // Product mux model feeding the DUT.
  always_comb begin
    in_adder       = '0;
    in_adder_valid = 1'b0;
    if (mux_sel < 4'd9) begin
      in_adder       = prods[mux_sel];
      in_adder_valid = (int'(mux_sel) != bad_tap);
    end
  end

  function automatic logic signed [SUM_W-1:0] model(input int skip);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      if (i != skip) s += int'(prods[i]);
    end
`ifdef CONV_ACC_CLAMP_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`endif
    return SUM_W'(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp(input int base, input int step);
    for (int i = 0; i < 9; i++) prods[i] = WIDTH'(base + step * i);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 9; i++) prods[i] = WIDTH'(v);
  endtask

  task automatic start_window;
    prod_valid = 1'b1;
    exp_q.push_back(model(bad_tap));
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic wait_result(output logic signed [SUM_W-1:0] d, output bit got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    d      = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (res_valid) begin
        got = 1'b1;
        d   = res_data;
      end else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    asserts++; if (mux_sel !== 4'd9) begin fails++; $display("FAIL reset_mux_sel: got %0d expected 9", mux_sel); end
    asserts++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL reset_prod_ready: got %b expected 1", prod_ready); end
    asserts++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    asserts++; if (res_data !== '0) begin fails++; $display("FAIL reset_res_data: got %0d expected 0", res_data); end
    asserts++; if (tap_err !== 1'b0) begin fails++; $display("FAIL reset_tap_err: got %b expected 0", tap_err); end
  endtask

  task automatic test_single_window;
    logic signed [SUM_W-1:0] exp;
    fill_ramp(100, 100);
    start_window();
    for (int k = 0; k < 9; k++) begin
      asserts++;
      if (mux_sel !== 4'(k)) begin fails++; $display("FAIL single_mux_sel_tap%0d: got %0d expected %0d", k, mux_sel, k); end
      tick();
    end
    exp = exp_q.pop_front();
    asserts++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_res_valid_t10: got %b expected 1", res_valid); end
    asserts++; if (res_data !== exp) begin fails++; $display("FAIL single_res_data: got %0d expected %0d", res_data, exp); end
    asserts++; if (tap_err !== 1'b0) begin fails++; $display("FAIL single_tap_err: got %b expected 0", tap_err); end
    handshake();
    asserts++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_after_xfer_valid: got %b expected 0", res_valid); end
    asserts++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL single_after_xfer_ready: got %b expected 1", prod_ready); end
  endtask

  task automatic test_negative;
    logic signed [SUM_W-1:0] d, exp;
    bit got;
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      fill_const(pass == 0 ? -100 : -8192);
      start_window();
      wait_result(d, got, cyc);
      exp = exp_q.pop_front();
      asserts++; if (!got) begin fails++; $display("FAIL negative%0d_timeout: got no result expected res_valid", pass); end
      asserts++; if (d !== exp) begin fails++; $display("FAIL negative%0d_res_data: got %0d expected %0d", pass, d, exp); end
      handshake();
    end
  endtask

  task automatic test_backpressure;
    logic signed [SUM_W-1:0] d, exp;
    bit got;
    int cyc;
    fill_ramp(10, 10);
    start_window();
    wait_result(d, got, cyc);
    exp = exp_q.pop_front();
    asserts++; if (!got) begin fails++; $display("FAIL bp_timeout: got no result expected res_valid"); end
    for (int i = 0; i < 5; i++) begin
      asserts++; if (res_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_c%0d: got %b expected 1", i, res_valid); end
      asserts++; if (res_data !== exp) begin fails++; $display("FAIL bp_data_c%0d: got %0d expected %0d", i, res_data, exp); end
      asserts++; if (mux_sel !== 4'd9) begin fails++; $display("FAIL bp_mux_sel_c%0d: got %0d expected 9", i, mux_sel); end
      asserts++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL bp_prod_ready_c%0d: got %b expected 0", i, prod_ready); end
      tick();
    end
    res_ready = 1'b1;
    #1;
    asserts++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", prod_ready); end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      asserts++; if (res_valid !== 1'b0) begin fails++; $display("FAIL bp_single_xfer_c%0d: got %b expected 0", i, res_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic signed [SUM_W-1:0] d, exp;
    bit got;
    int cyc;
    fill_ramp(100, 100);
    res_ready  = 1'b1;
    prod_valid = 1'b1;
    exp_q.push_back(model(-1));
    tick();
    asserts++; if (mux_sel !== 4'd0) begin fails++; $display("FAIL b2b_first_tap: got %0d expected 0", mux_sel); end
    wait_result(d, got, cyc);
    exp = exp_q.pop_front();
    asserts++; if (!got || cyc != 9) begin fails++; $display("FAIL b2b_first_latency: got %0d cycles expected 9", cyc); end
    asserts++; if (d !== exp) begin fails++; $display("FAIL b2b_first_data: got %0d expected %0d", d, exp); end
    fill_const(1);
    exp_q.push_back(model(-1));
    tick();
    asserts++; if (mux_sel !== 4'd0 || res_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_idle: got mux_sel %0d valid %b expected 0 0", mux_sel, res_valid); end
    wait_result(d, got, cyc);
    exp = exp_q.pop_front();
    asserts++; if (!got || cyc != 9) begin fails++; $display("FAIL b2b_second_interval: got %0d cycles expected 9", cyc); end
    asserts++; if (d !== exp) begin fails++; $display("FAIL b2b_second_data: got %0d expected %0d", d, exp); end
    prod_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    asserts++; if (res_valid !== 1'b0 || prod_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle: got valid %b ready %b expected 0 1", res_valid, prod_ready); end
  endtask

  task automatic test_reset_mid;
    logic signed [SUM_W-1:0] d, exp;
    bit got;
    int cyc;
    fill_ramp(100, 100);
    start_window();
    for (int i = 0; i < 4; i++) tick();
    asserts++; if (mux_sel !== 4'd4) begin fails++; $display("FAIL rstmid_at_tap4: got %0d expected 4", mux_sel); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    asserts++; if (mux_sel !== 4'd9) begin fails++; $display("FAIL rstmid_mux_sel: got %0d expected 9", mux_sel); end
    asserts++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rstmid_res_valid: got %b expected 0", res_valid); end
    asserts++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL rstmid_prod_ready: got %b expected 1", prod_ready); end
    fill_ramp(1, 1);
    start_window();
    wait_result(d, got, cyc);
    exp = exp_q.pop_front();
    asserts++; if (!got) begin fails++; $display("FAIL rstmid_timeout: got no result expected res_valid"); end
    asserts++; if (d !== exp) begin fails++; $display("FAIL rstmid_fresh_data: got %0d expected %0d", d, exp); end
    handshake();
  endtask

  task automatic test_tap_err;
    logic signed [SUM_W-1:0] d, exp;
    bit got;
    int cyc;
    fill_ramp(100, 100);
    bad_tap = 3;
    start_window();
    wait_result(d, got, cyc);
    exp = exp_q.pop_front();
    asserts++; if (!got) begin fails++; $display("FAIL taperr_timeout: got no result expected res_valid"); end
    asserts++; if (d !== exp) begin fails++; $display("FAIL taperr_data: got %0d expected %0d", d, exp); end
    asserts++; if (tap_err !== 1'b1) begin fails++; $display("FAIL taperr_set: got %b expected 1", tap_err); end
    handshake();
    bad_tap = -1;
    fill_const(2);
    start_window();
    wait_result(d, got, cyc);
    exp = exp_q.pop_front();
    asserts++; if (d !== exp) begin fails++; $display("FAIL taperr_clean_data: got %0d expected %0d", d, exp); end
    asserts++; if (tap_err !== 1'b1) begin fails++; $display("FAIL taperr_sticky: got %b expected 1", tap_err); end
    handshake();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++; if (tap_err !== 1'b0) begin fails++; $display("FAIL taperr_cleared: got %b expected 0", tap_err); end
  endtask

  initial begin
    rst        = 1'b1;
    prod_valid = 1'b0;
    res_ready  = 1'b0;
    fill_const(0);
    #1;
    test_reset();
    test_single_window();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_tap_err();
    asserts++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Sequential accumulate stage of the convolution datapath. It sits directly downstream of the 9-tap product mux and drives that mux's `mux_sel`. For each accepted window it steps the tap index from 0 to 8 and sums the nine signed products presented on `in_adder`. It then presents one result word to the next stage under a valid/ready handshake.

## Interface
- `WIDTH`, 14: signed width of each product (`in_adder`).
- `TAPS`, 9: taps per window; fixed at 9 for the 3x3 kernel.
- `SUM_W`, `WIDTH+4` (18): accumulator and result width; guarantees no overflow for 9 terms.

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `prod_valid` in 1: all nine products for a window are stable at the mux inputs.
- `prod_ready` out 1: the block accepts a window this cycle.
- `mux_sel` out 4: tap index driven to the product mux; 0..8 active, 9 = idle.
- `in_adder` in `WIDTH` signed: selected product returned by the mux.
- `in_adder_valid` in 1: the mux's valid for `in_adder`.
- `res_data` out `SUM_W` signed: convolution result.
- `res_valid` out 1: `res_data` is valid.
- `res_ready` in 1: downstream accepts the result.
- `tap_err` out 1: sticky flag; a tap arrived without `in_adder_valid`.

## Operation
- FSM states:
  - IDLE:
    - `prod_ready`=1, `mux_sel`=9.
    - `prod_valid`=1 → clear `acc` and `tap_cnt`, go to ACC.
  - ACC:
    - `mux_sel`=`tap_cnt`.
    - Each cycle, if `in_adder_valid`: `acc` += sign-extended `in_adder`. Otherwise skip the term and set `tap_err`.
    - `tap_cnt` increments each cycle. At `tap_cnt`=8, go to DONE after the add.
  - DONE:
    - `res_valid`=1; `res_data` holds the registered final value; `mux_sel`=9.
    - `res_ready`=1 → handshake completes.
    - If `prod_valid` is also 1 in that cycle, go straight to ACC with `acc` and `tap_cnt` cleared. Otherwise go to IDLE.
- `prod_ready` = (state==IDLE) | (state==DONE & `res_ready`).
- `res_data`, `res_valid` and `mux_sel` are registered or pure state decodes; they are stable while `res_valid`=1 and `res_ready`=0.
- Products are sampled only in ACC. Upstream must hold the products stable from acceptance through tap 8.
- Arithmetic:
  - Two's complement, sign-extend `WIDTH`→`SUM_W`.
  - No wrap is possible: the worst case is 9×(−8192) = −73728, which fits in 18-bit signed.
- Boundaries:
  - `prod_valid` in ACC is ignored; it is not queued.
  - `tap_err` clears only on `rst`.

## Timing
- Reset values:
  - state=IDLE, `mux_sel`=9, `prod_ready`=1.
  - `res_valid`=0, `res_data`=0, `tap_err`=0.
  - `acc`=0, `tap_cnt`=0.
- `rst` mid-ACC or mid-DONE: the next cycle shows the reset values. The partial sum is discarded and no result is emitted.
- Latency:
  - Window accepted at edge T → `mux_sel`=0 during cycle T+1, …, `mux_sel`=8 during T+9.
  - `res_valid`=1 from T+10.
- Throughput: one window per 10 cycles with `res_ready` held high (back-to-back accept in DONE).
- Combinational path: `mux_sel`→mux→`in_adder`→adder. It must close within one cycle at the target clock.

## Configuration
- `CONV_ACC_CLAMP_EN` defined:
  - `res_data` = `acc` clamped to the 8-bit pixel range [0,255], zero-extended to `SUM_W`.
  - The clamp is applied when registering the DONE value.
- `CONV_ACC_CLAMP_EN` undefined:
  - `res_data` = raw signed `acc`.
- Interface and timing are identical in both builds.

## Structure
- Shared package `conv_pkg`:
  - `WIDTH`, `TAPS`, `SUM_W` defaults.
  - `MUX_SEL_IDLE`=4'd9.
  - `acc_state_t` enum {IDLE, ACC, DONE}.
  - `PIX_MAX`=255.
- One sub-module, `conv_tap_counter`:
  - Inputs: clear/enable.
  - Outputs: `tap_cnt` and a `last` flag at `TAPS`−1.
  - Reused by the line-buffer window stage.

## Test plan
- Reset then one window: products 100,200,…,900 → `mux_sel` 0..8 over T+1..T+9; `res_valid` at T+10; `res_data`=4500 (255 with `CONV_ACC_CLAMP_EN`); `tap_err`=0.
- All products −100 → `res_data`=−900 (0 with `CONV_ACC_CLAMP_EN`); nine products −8192 → −73728, no wrap.
- Backpressure: hold `res_ready`=0 for 5 cycles after `res_valid` → `res_data` and `res_valid` stable, `mux_sel`=9, `prod_ready`=0; release → exactly one transfer.
- Back-to-back: `prod_valid` and `res_ready` held high → results every 10 cycles with no idle cycle; second window 1,1,…,1 gives 9.
- Reset asserted at tap 4 → next cycle `mux_sel`=9, `res_valid`=0, `prod_ready`=1; a fresh window then gives the correct sum with no residue.
- Force `in_adder_valid`=0 at tap 3 with products 100..900 → `res_data`=4100, `tap_err`=1 and held until `rst`.
